// File: rtl/md_if.sv
// Handshake and result bus between EX and the multiply/divide unit.
// The master side is EX, which issues operations. The slave side is md_unit, which owns HI/LO.
interface md_if;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  md_op;
  logic        start;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output a,
    output b,
    output md_op,
    output start,
    input  busy,
    input  hi,
    input  lo
  );

  modport slave (
    input  a,
    input  b,
    input  md_op,
    input  start,
    output busy,
    output hi,
    output lo
  );
endinterface

// File: rtl/md_unit.sv
// Multiply/divide unit: holds architectural HI/LO. Runs mult/div with a fixed Busy latency.
// The result is computed at issue and parked in pending registers until the countdown expires.
module md_unit #(
  parameter int unsigned MultCycles = 5,
  parameter int unsigned DivCycles  = 10
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  md_if.slave   md
);

  typedef enum logic [2:0] {
    OpNone  = 3'd0,
    OpMult  = 3'd1,
    OpMultu = 3'd2,
    OpDiv   = 3'd3,
    OpDivu  = 3'd4,
    OpMthi  = 3'd5,
    OpMtlo  = 3'd6,
    OpRsvd  = 3'd7
  } md_op_e;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StRun  = 1'b1
  } state_e;

  localparam logic [3:0] MultLoad = 4'(MultCycles);
  localparam logic [3:0] DivLoad  = 4'(DivCycles);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] pend_hi_q, pend_hi_d;
  logic [31:0] pend_lo_q, pend_lo_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  md_op_e op;
  assign op = md_op_e'(md.md_op);

  // Multiply: sign- or zero-extend to 64 bits, keep the low 64 product bits.
  logic [63:0] a_sext, b_sext, a_zext, b_zext;
  logic [63:0] prod_s, prod_u;

  assign a_sext = {{32{md.a[31]}}, md.a};
  assign b_sext = {{32{md.b[31]}}, md.b};
  assign a_zext = {32'd0, md.a};
  assign b_zext = {32'd0, md.b};
  assign prod_s = a_sext * b_sext;
  assign prod_u = a_zext * b_zext;

  // Signed divide on magnitudes; 0x80000000 / -1 wraps back to 0x80000000 without a special case.
  logic        div_zero;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [31:0] q_mag, r_mag;
  logic [31:0] q_s, r_s;
  logic [31:0] q_u, r_u;

  assign div_zero = (md.b == 32'd0);
  assign a_neg    = md.a[31];
  assign b_neg    = md.b[31];
  assign a_mag    = a_neg ? (32'd0 - md.a) : md.a;
  assign b_mag    = b_neg ? (32'd0 - md.b) : md.b;
  assign q_mag    = div_zero ? 32'd0 : (a_mag / b_mag);
  assign r_mag    = div_zero ? 32'd0 : (a_mag % b_mag);
  assign q_s      = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
  assign r_s      = a_neg ? (32'd0 - r_mag) : r_mag;
  assign q_u      = div_zero ? 32'd0 : (md.a / md.b);
  assign r_u      = div_zero ? 32'd0 : (md.a % md.b);

  logic [31:0] res_hi, res_lo;
  logic        is_long_op;
  logic [3:0]  load_cnt;

  always_comb begin
    res_hi     = 32'd0;
    res_lo     = 32'd0;
    is_long_op = 1'b0;
    load_cnt   = 4'd0;
    unique case (op)
      OpMult: begin
        res_hi     = prod_s[63:32];
        res_lo     = prod_s[31:0];
        is_long_op = 1'b1;
        load_cnt   = MultLoad;
      end
      OpMultu: begin
        res_hi     = prod_u[63:32];
        res_lo     = prod_u[31:0];
        is_long_op = 1'b1;
        load_cnt   = MultLoad;
      end
      OpDiv: begin
        res_hi     = div_zero ? md.a : r_s;
        res_lo     = div_zero ? 32'hFFFF_FFFF : q_s;
        is_long_op = 1'b1;
        load_cnt   = DivLoad;
      end
      OpDivu: begin
        res_hi     = div_zero ? md.a : r_u;
        res_lo     = div_zero ? 32'hFFFF_FFFF : q_u;
        is_long_op = 1'b1;
        load_cnt   = DivLoad;
      end
      OpNone, OpMthi, OpMtlo, OpRsvd: begin
        is_long_op = 1'b0;
      end
      default: begin
        is_long_op = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    unique case (state_q)
      StIdle: begin
        if (md.start) begin
          if (is_long_op) begin
            pend_hi_d = res_hi;
            pend_lo_d = res_lo;
            cnt_d     = load_cnt;
            state_d   = StRun;
          end else if (op == OpMthi) begin
            hi_d = md.a;
          end else if (op == OpMtlo) begin
            lo_d = md.a;
          end
        end
      end
      StRun: begin
        // Start is deliberately ignored here, including on the completion edge.
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          hi_d    = pend_hi_q;
          lo_d    = pend_lo_q;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign md.busy = (state_q == StRun);
  assign md.hi   = hi_q;
  assign md.lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit.
// Random and directed operations are checked against a 64-bit arithmetic reference model.
module tb_md_unit;

  localparam int unsigned NMult = 5;
  localparam int unsigned NDiv  = 10;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  md_if u_if ();

  md_unit #(
    .MultCycles (NMult),
    .DivCycles  (NDiv)
  ) u_dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .md     (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference result {HI, LO} from plain 64-bit arithmetic.
  function automatic logic [63:0] ref_md(input int op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, q, r;
    longint unsigned ua, ub, p;
    logic [63:0]     res;
    res = 64'd0;
    case (op)
      1: begin
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        res = 64'(sa * sb);
      end
      2: begin
        ua  = longint'(a);
        ub  = longint'(b);
        p   = ua * ub;
        res = p;
      end
      3: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else begin
          sa  = longint'($signed(a));
          sb  = longint'($signed(b));
          q   = sa / sb;
          r   = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      4: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else res = {a % b, a / b};
      end
      default: res = 64'd0;
    endcase
    return res;
  endfunction

  task automatic issue(input int op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    u_if.start = 1'b1;
    u_if.md_op = 3'(op);
    u_if.a     = a;
    u_if.b     = b;
    @(negedge clk);
    u_if.start = 1'b0;
    u_if.md_op = 3'd0;
  endtask

  // Issue a long op, watch Busy, check HI/LO hold then take the model result.
  task automatic run_op(input int op, input logic [31:0] a, input logic [31:0] b,
                        input bit disturb, input string name);
    logic [63:0] exp;
    int          cnt;
    int unsigned n;
    exp = ref_md(op, a, b);
    n   = (op <= 2) ? NMult : NDiv;
    issue(op, a, b);
    cnt = 0;
    while (u_if.busy === 1'b1 && cnt < 40) begin
      total++;
      if (u_if.hi !== m_hi || u_if.lo !== m_lo) begin
        bad++;
        $display("FAIL %s hold: hi=%h lo=%h expected hi=%h lo=%h", name, u_if.hi, u_if.lo,
                 m_hi, m_lo);
      end
      if (disturb) begin
        u_if.start = 1'b1;
        u_if.md_op = 3'($urandom_range(1, 7));
        u_if.a     = $urandom;
        u_if.b     = $urandom;
      end
      @(negedge clk);
      cnt++;
    end
    u_if.start = 1'b0;
    u_if.md_op = 3'd0;
    total++;
    if (cnt != int'(n)) begin
      bad++;
      $display("FAIL %s busy_cycles: got %0d expected %0d", name, cnt, n);
    end
    m_hi = exp[63:32];
    m_lo = exp[31:0];
    total++;
    if (u_if.hi !== m_hi) begin
      bad++;
      $display("FAIL %s hi: got %h expected %h", name, u_if.hi, m_hi);
    end
    total++;
    if (u_if.lo !== m_lo) begin
      bad++;
      $display("FAIL %s lo: got %h expected %h", name, u_if.lo, m_lo);
    end
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    u_if.start = 1'b0;
    u_if.md_op = 3'd0;
    u_if.a     = 32'd0;
    u_if.b     = 32'd0;
    m_hi       = 32'd0;
    m_lo       = 32'd0;
    #3;
    total++;
    if (u_if.busy !== 1'b0 || u_if.hi !== 32'd0 || u_if.lo !== 32'd0) begin
      bad++;
      $display("FAIL reset_state: busy=%b hi=%h lo=%h expected 0 0 0", u_if.busy, u_if.hi,
               u_if.lo);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_mthi_mtlo();
    @(negedge clk);
    u_if.start = 1'b1;
    u_if.md_op = 3'd5;
    u_if.a     = 32'hDEAD_BEEF;
    @(negedge clk);
    total++;
    if (u_if.hi !== 32'hDEAD_BEEF || u_if.lo !== 32'd0 || u_if.busy !== 1'b0) begin
      bad++;
      $display("FAIL mthi: hi=%h lo=%h busy=%b expected deadbeef 0 0", u_if.hi, u_if.lo,
               u_if.busy);
    end
    u_if.md_op = 3'd6;
    u_if.a     = 32'h0BAD_F00D;
    @(negedge clk);
    u_if.start = 1'b0;
    u_if.md_op = 3'd0;
    total++;
    if (u_if.hi !== 32'hDEAD_BEEF || u_if.lo !== 32'h0BAD_F00D || u_if.busy !== 1'b0) begin
      bad++;
      $display("FAIL mtlo: hi=%h lo=%h busy=%b expected deadbeef 0badf00d 0", u_if.hi, u_if.lo,
               u_if.busy);
    end
    m_hi = 32'hDEAD_BEEF;
    m_lo = 32'h0BAD_F00D;
  endtask

  task automatic test_noop();
    int ops[4] = '{0, 7, 1, 5};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      u_if.start = (i < 2);
      u_if.md_op = 3'(ops[i]);
      u_if.a     = $urandom;
      u_if.b     = $urandom;
      @(negedge clk);
      u_if.start = 1'b0;
      u_if.md_op = 3'd0;
      total++;
      if (u_if.busy !== 1'b0 || u_if.hi !== m_hi || u_if.lo !== m_lo) begin
        bad++;
        $display("FAIL noop_%0d: busy=%b hi=%h lo=%h expected 0 %h %h", i, u_if.busy, u_if.hi,
                 u_if.lo, m_hi, m_lo);
      end
    end
  endtask

  task automatic test_mult();
    run_op(1, 32'hFFFF_FFFE, 32'd3, 1'b0, "mult");
    total++;
    if (u_if.hi !== 32'hFFFF_FFFF || u_if.lo !== 32'hFFFF_FFFA) begin
      bad++;
      $display("FAIL mult_const: hi=%h lo=%h expected ffffffff fffffffa", u_if.hi, u_if.lo);
    end
    run_op(2, 32'hFFFF_FFFE, 32'd3, 1'b0, "multu");
    total++;
    if (u_if.hi !== 32'h0000_0002 || u_if.lo !== 32'hFFFF_FFFA) begin
      bad++;
      $display("FAIL multu_const: hi=%h lo=%h expected 00000002 fffffffa", u_if.hi, u_if.lo);
    end
  endtask

  task automatic test_div();
    run_op(3, 32'hFFFF_FFF9, 32'd2, 1'b0, "div");
    total++;
    if (u_if.hi !== 32'hFFFF_FFFF || u_if.lo !== 32'hFFFF_FFFD) begin
      bad++;
      $display("FAIL div_const: hi=%h lo=%h expected ffffffff fffffffd", u_if.hi, u_if.lo);
    end
    run_op(4, 32'd7, 32'd2, 1'b0, "divu");
    total++;
    if (u_if.hi !== 32'd1 || u_if.lo !== 32'd3) begin
      bad++;
      $display("FAIL divu_const: hi=%h lo=%h expected 1 3", u_if.hi, u_if.lo);
    end
  endtask

  task automatic test_div_boundary();
    run_op(3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf");
    total++;
    if (u_if.hi !== 32'd0 || u_if.lo !== 32'h8000_0000) begin
      bad++;
      $display("FAIL div_ovf_const: hi=%h lo=%h expected 0 80000000", u_if.hi, u_if.lo);
    end
    run_op(4, 32'h1234_5678, 32'd0, 1'b0, "divu_zero");
    total++;
    if (u_if.hi !== 32'h1234_5678 || u_if.lo !== 32'hFFFF_FFFF) begin
      bad++;
      $display("FAIL divu_zero_const: hi=%h lo=%h expected 12345678 ffffffff", u_if.hi,
               u_if.lo);
    end
    run_op(3, 32'hFFFF_FFF0, 32'd0, 1'b0, "div_zero");
  endtask

  task automatic test_disturb();
    run_op(3, 32'hFFFF_FC00, 32'd7, 1'b1, "div_disturb");
    run_op(1, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1, "mult_disturb");
  endtask

  task automatic test_random();
    int          op;
    logic [31:0] a, b;
    for (int i = 0; i < 24; i++) begin
      op = $urandom_range(1, 6);
      a  = $urandom;
      b  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 9));
      if (op <= 4) begin
        run_op(op, a, b, 1'($urandom_range(0, 1)), "random");
      end else begin
        issue(op, a, b);
        if (op == 5) m_hi = a;
        else m_lo = a;
        total++;
        if (u_if.busy !== 1'b0 || u_if.hi !== m_hi || u_if.lo !== m_lo) begin
          bad++;
          $display("FAIL random_mt%0d: busy=%b hi=%h lo=%h expected 0 %h %h", op, u_if.busy,
                   u_if.hi, u_if.lo, m_hi, m_lo);
        end
      end
    end
  endtask

  task automatic test_reset_midop();
    issue(5, 32'hCAFE_0001, 32'd0);
    issue(6, 32'hCAFE_0002, 32'd0);
    issue(1, 32'h0001_0000, 32'h0001_0000);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if (u_if.busy !== 1'b0 || u_if.hi !== 32'd0 || u_if.lo !== 32'd0) begin
      bad++;
      $display("FAIL reset_midop: busy=%b hi=%h lo=%h expected 0 0 0", u_if.busy, u_if.hi,
               u_if.lo);
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_hi  = 32'd0;
    m_lo  = 32'd0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      total++;
      if (u_if.busy !== 1'b0 || u_if.hi !== 32'd0 || u_if.lo !== 32'd0) begin
        bad++;
        $display("FAIL reset_late_write: cycle %0d busy=%b hi=%h lo=%h expected 0 0 0", i,
                 u_if.busy, u_if.hi, u_if.lo);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_mthi_mtlo();
    test_noop();
    test_mult();
    test_div();
    test_div_boundary();
    test_disturb();
    test_random();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
